// File: rtl/day2_dff_variants.sv
// day2_dff_variants: three parallel D registers on one data input.
// They differ only in reset style: none, synchronous, or asynchronous.
`default_nettype none

module day2_dff_variants #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_norst_o,
   output logic [WIDTH-1:0] q_syncrst_o,
   output logic [WIDTH-1:0] q_asyncrst_o
);

   // No reset at all: this register powers up undefined and is never cleared.
   always_ff @(posedge clk) begin
      q_norst_o <= d_i;
   end

   // Reset is sampled only at the clock edge, so it behaves like a data input.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_syncrst_o <= RST_VAL;
      end else begin
         q_syncrst_o <= d_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_asyncrst_o <= RST_VAL;
      end else begin
         q_asyncrst_o <= d_i;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_day2_dff_variants.sv
// Bench for day2_dff_variants: a 1-bit default instance and an 8-bit instance
// with a reset value of 8'hA5, driven from the same clock and reset.
`default_nettype none

module tb_day2_dff_variants;

   logic       clk;
   logic       reset;
   logic       d;
   logic [7:0] d8;
   logic       qn, qs, qa;
   logic [7:0] qn8, qs8, qa8;

   int pass_cnt = 0;
   int total_cnt = 0;

   day2_dff_variants u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .d_i          (d),
      .q_norst_o    (qn),
      .q_syncrst_o  (qs),
      .q_asyncrst_o (qa)
   );

   day2_dff_variants #(
      .WIDTH   (8),
      .RST_VAL (8'hA5)
   ) u_dut8 (
      .clk          (clk),
      .reset        (reset),
      .d_i          (d8),
      .q_norst_o    (qn8),
      .q_syncrst_o  (qs8),
      .q_asyncrst_o (qa8)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic       d;
      logic [7:0] d8;
      logic       en, es, ea;
      logic [7:0] en8, es8, ea8;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic check1(input string name, input logic en, input logic es, input logic ea);
      check({name, ".norst"}, {7'd0, qn}, {7'd0, en});
      check({name, ".sync"},  {7'd0, qs}, {7'd0, es});
      check({name, ".async"}, {7'd0, qa}, {7'd0, ea});
   endtask

   initial begin
      // rst, d, d8 | expected 1-bit n,s,a | expected 8-bit n,s,a  (after the edge)
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 8'h11, 8'h11};
      vecs[2]  = '{1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hF0, 8'hF0};
      vecs[3]  = '{1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 8'h0F, 8'h0F, 8'h0F};
      // held in reset with d_i = 1
      vecs[4]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
      vecs[5]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
      vecs[6]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
      // still in reset, d_i toggling: only the unreset register follows
      vecs[7]  = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hA5, 8'hA5};
      vecs[8]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
      // released
      vecs[9]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'h3C};
      vecs[10] = '{1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3, 8'hC3};
      vecs[11] = '{1'b1, 1'b1, 8'h96, 1'b1, 1'b1, 1'b1, 8'h96, 8'h96, 8'h96};
      vecs[12] = '{1'b1, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0, 8'h69, 8'h69, 8'h69};
      vecs[13] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF};

      reset = 1'b1;
      d     = 1'b0;
      d8    = 8'h00;
      // Brief reset before the first edge: async outputs clear without a clock.
      #1 reset = 1'b0;
      #1;
      check("init.async",  {7'd0, qa}, 8'h00);
      check("init.async8", qa8, 8'hA5);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         if (i != 0) @(negedge clk);
         reset = vecs[i].rst;
         d     = vecs[i].d;
         d8    = vecs[i].d8;
         @(posedge clk);
         #2;
         check1($sformatf("vec%0d", i), vecs[i].en, vecs[i].es, vecs[i].ea);
         check($sformatf("vec%0d.norst8", i), qn8, vecs[i].en8);
         check($sformatf("vec%0d.sync8", i),  qs8, vecs[i].es8);
         check($sformatf("vec%0d.async8", i), qa8, vecs[i].ea8);
      end

      // Reset asserted midway between edges with all outputs at 1.
      @(negedge clk);
      reset = 1'b0;
      #2;
      check1("mid_assert", 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      check1("mid_assert_edge", 1'b1, 1'b0, 1'b0);

      // Release immediately after an edge: that edge still saw reset low.
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check1("release_edge", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check1("release_next", 1'b1, 1'b1, 1'b1);

      // Quarter-period reset pulse falling entirely between edges.
      #3 reset = 1'b0;
      #2;
      check1("pulse_low", 1'b1, 1'b1, 1'b0);
      #3 reset = 1'b1;
      #2;
      check1("pulse_after", 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      check1("pulse_edge", 1'b1, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
